arm_instr_encoder: RTL

- Inverse of the instruction classifier: takes a classified instruction request and assembles the 32-bit ARM word.
  - Request fields: instruction type, sub-op, condition, registers, immediate.
- Sits between the test-program sequencer and instruction memory. Lets benches and the boot loader generate legal words without hand-packed hex.
- Valid/ready handshake on both sides. Encoded words are buffered in a small FIFO.

---
 rtl/arm_instr_encoder_pkg.sv | 35 +++
 rtl/arm_instr_encoder_if.sv | 39 +++
 rtl/arm_instr_encoder_enc_fifo.sv | 62 ++++++
 rtl/arm_instr_encoder.sv | 108 ++++++++++
 4 files changed

// File: rtl/arm_instr_encoder_pkg.sv
// Shared encodings for the ARM instruction encoder. Type, memory-op and
// branch-op codes match the instruction classifier so the two blocks round-trip.
package arm_enc_pkg;

    typedef enum logic [2:0] {
        TYPE_DP_IMM       = 3'd0,
        TYPE_DP_REG_SHIMM = 3'd1,
        TYPE_DP_REG_SHREG = 3'd2,
        TYPE_MUL          = 3'd3,
        TYPE_MEM_IMM      = 3'd4,
        TYPE_MEM_REG      = 3'd5,
        TYPE_BRANCH       = 3'd6,
        TYPE_ILLEGAL      = 3'd7
    } instr_type_e;

    typedef enum logic [1:0] {
        MEM_STR  = 2'd0,
        MEM_LDR  = 2'd1,
        MEM_STRB = 2'd2,
        MEM_LDRB = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        JMP_B  = 2'd0,
        JMP_BL = 2'd1
    } jmp_op_e;

    localparam logic [1:0]  CLASS_DP  = 2'b00;
    localparam logic [1:0]  CLASS_MEM = 2'b01;
    localparam logic [1:0]  CLASS_BR  = 2'b10;

    localparam logic [3:0]  COND_AL = 4'hE;
    localparam logic [31:0] NOP     = 32'hE1A0_0000;  // MOV r0, r0

endpackage

// File: rtl/arm_instr_encoder_if.sv
// Request/response bus of the ARM instruction encoder: classified request in,
// encoded word out, each with its own valid/ready handshake.
interface arm_instr_encoder_if;
    import arm_enc_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [3:0]  in_dp_op;
    logic [1:0]  in_mem_op;
    logic [1:0]  in_jmp_op;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic [3:0]  in_rd;
    logic [3:0]  in_rn;
    logic [3:0]  in_rm;
    logic [3:0]  in_rs;
    logic [23:0] in_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    // Encoder side
    modport slave (
        input  in_valid, in_type, in_dp_op, in_mem_op, in_jmp_op, in_cond,
               in_set_flags, in_rd, in_rn, in_rm, in_rs, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

    // Sequencer / consumer side
    modport master (
        output in_valid, in_type, in_dp_op, in_mem_op, in_jmp_op, in_cond,
               in_set_flags, in_rd, in_rn, in_rm, in_rs, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/arm_instr_encoder_enc_fifo.sv
// Synchronous FIFO of {err, word} entries with full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    import arm_enc_pkg::*;

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage; cleared on reset so the head reads as zero before the first push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arm_instr_encoder.sv
// ARM instruction encoder: assembles a 32-bit ARM word from a classified
// request and buffers it in a small FIFO. Illegal requests become NOP_WORD
// with the error flag set.
// Optional: define ARM_ENC_STATS_EN to add the stat_illegal counter port.
module arm_instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_WORD   = 32'hE1A0_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    arm_instr_encoder_if.slave   bus
`ifdef ARM_ENC_STATS_EN
    ,
    output logic [15:0]          stat_illegal
`endif
);
    import arm_enc_pkg::*;

    logic [31:0] enc_word;
    logic        enc_err;
    logic        accept;
    logic        fifo_full;
    logic        fifo_empty;
    logic [32:0] head;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_err   = head[32];
    assign bus.out_instr = head[31:0];

    // Encode mux: field placement per instruction type
    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
        case (instr_type_e'(bus.in_type))
            TYPE_DP_IMM: begin
                enc_word = {bus.in_cond, CLASS_DP, 1'b1, bus.in_dp_op, bus.in_set_flags,
                            bus.in_rn, bus.in_rd, bus.in_imm[11:0]};
                enc_err  = 1'b0;
            end
            TYPE_DP_REG_SHIMM: begin
                enc_word = {bus.in_cond, CLASS_DP, 1'b0, bus.in_dp_op, bus.in_set_flags,
                            bus.in_rn, bus.in_rd, bus.in_imm[11:5], 1'b0, bus.in_rm};
                enc_err  = 1'b0;
            end
            TYPE_DP_REG_SHREG: begin
                enc_word = {bus.in_cond, CLASS_DP, 1'b0, bus.in_dp_op, bus.in_set_flags,
                            bus.in_rn, bus.in_rd, bus.in_rs, 1'b0, bus.in_imm[6:5],
                            1'b1, bus.in_rm};
                enc_err  = 1'b0;
            end
            TYPE_MUL: begin
                enc_word = {bus.in_cond, 7'b000_0000, bus.in_set_flags, bus.in_rd,
                            4'b0000, bus.in_rs, 4'b1001, bus.in_rm};
                enc_err  = 1'b0;
            end
            TYPE_MEM_IMM: begin
                // P=1, U=1, W=0; B and L come straight from the mem op code
                enc_word = {bus.in_cond, CLASS_MEM, 1'b0, 1'b1, 1'b1, bus.in_mem_op[1],
                            1'b0, bus.in_mem_op[0], bus.in_rn, bus.in_rd, bus.in_imm[11:0]};
                enc_err  = 1'b0;
            end
            TYPE_MEM_REG: begin
                enc_word = {bus.in_cond, CLASS_MEM, 1'b1, 1'b1, 1'b1, bus.in_mem_op[1],
                            1'b0, bus.in_mem_op[0], bus.in_rn, bus.in_rd,
                            bus.in_imm[11:5], 1'b0, bus.in_rm};
                enc_err  = 1'b0;
            end
            TYPE_BRANCH: begin
                if (bus.in_jmp_op == JMP_B || bus.in_jmp_op == JMP_BL) begin
                    enc_word = {bus.in_cond, CLASS_BR, 1'b1, bus.in_jmp_op[0], bus.in_imm};
                    enc_err  = 1'b0;
                end
            end
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (accept),
        .push_data ({enc_err, enc_word}),
        .pop       (bus.out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef ARM_ENC_STATS_EN
    // Saturating count of accepted illegal requests
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_illegal <= '0;
        end else if (accept && enc_err && (stat_illegal != '1)) begin
            stat_illegal <= stat_illegal + 16'd1;
        end
    end
`endif

endmodule
